// File: rtl/mandala_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers for the mandala tile.
package mandala_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_TOTAL      = 10'd800;

    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    localparam logic [9:0] CENTER_X     = 10'd320;
    localparam logic [9:0] CENTER_Y     = 10'd240;

    // Distance from the screen centre along one axis, always non-negative.
    function automatic logic [9:0] absDiff(input logic [9:0] p, input logic [9:0] q);
        return (p >= q) ? (p - q) : (q - p);
    endfunction

endpackage

// File: rtl/mandala_vga_timing.sv
// Horizontal/vertical raster counters with combinational sync, visible and
// end-of-frame decodes derived from the current counter values.
import mandala_pkg::*;

module mandala_vga_timing (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hcount_o,
    output logic [9:0] vcount_o,
    output logic       visible_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o,
    output logic       frame_end_o
);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;

    // Next raster position: hcount wraps at the end of each line, vcount steps on that wrap.
    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_TOTAL - 10'd1) begin
            hcount_d = '0;
            if (vcount_q == V_TOTAL - 10'd1) begin
                vcount_d = '0;
            end else begin
                vcount_d = vcount_q + 10'd1;
            end
        end
    end

    // Raster position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount_o    = hcount_q;
    assign vcount_o    = vcount_q;
    assign visible_o   = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);
    assign hsync_n_o   = !((hcount_q >= H_SYNC_START) && (hcount_q <= H_SYNC_END));
    assign vsync_n_o   = !((vcount_q >= V_SYNC_START) && (vcount_q <= V_SYNC_END));
    assign frame_end_o = (hcount_q == H_TOTAL - 10'd1) && (vcount_q == V_TOTAL - 10'd1);

endmodule

// File: rtl/tt_um_monish_mandala_art.sv
// TinyTapeout VGA mandala generator: folds the raster into one octant around the
// screen centre and maps it to an RGB222 colour on the TinyVGA pinout.
// Optional build macro MANDALA_ANIM_EN adds a per-frame palette phase counter
// gated by ui_in[0]; without it the pattern is static.
import mandala_pkg::*;

module tt_um_monish_mandala_art (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [9:0]  hcount, vcount;
    logic        visible, hsyncN, vsyncN, frameEnd;
    logic [9:0]  ax, ay, foldA, foldB;
    logic [10:0] foldSum;
    logic [9:0]  foldXor;
    logic [5:0]  colourIdx;
    logic [5:0]  phase;
    logic [7:0]  pixel_d, pixel_q;

    mandala_vga_timing timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcount_o    (hcount),
        .vcount_o    (vcount),
        .visible_o   (visible),
        .hsync_n_o   (hsyncN),
        .vsync_n_o   (vsyncN),
        .frame_end_o (frameEnd)
    );

`ifdef MANDALA_ANIM_EN
    logic [5:0] phase_q, phase_d;

    // Advance the palette phase once per frame while animation is requested.
    always_comb begin
        phase_d = phase_q;
        if (frameEnd && ui_in[0]) begin
            phase_d = phase_q + 6'd1;
        end
    end

    // Palette phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    logic unusedBits;
    assign unusedBits = ^{ena, uio_in, ui_in[1]};
`else
    assign phase = '0;
    logic unusedBits;
    assign unusedBits = ^{ena, uio_in, ui_in[1:0], frameEnd};
`endif

    // Fold into one octant, build the colour index and pack the TinyVGA output byte.
    always_comb begin
        ax        = absDiff(hcount, CENTER_X);
        ay        = absDiff(vcount, CENTER_Y);
        foldA     = (ax >= ay) ? ax : ay;
        foldB     = (ax >= ay) ? ay : ax;
        foldSum   = {1'b0, foldA} + {1'b0, foldB};
        foldXor   = foldA ^ foldB;
        colourIdx = foldSum[7:2] + foldXor[7:2] + phase + ui_in[7:2];
        if (!visible) begin
            colourIdx = '0;
        end
        pixel_d = {hsyncN, colourIdx[0], colourIdx[2], colourIdx[4],
                   vsyncN, colourIdx[1], colourIdx[3], colourIdx[5]};
    end

    logic unusedFold;
    assign unusedFold = ^{foldSum[10:8], foldSum[1:0], foldXor[9:8], foldXor[1:0]};

    // Output register keeps sync and colour in the same pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= 8'h88;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign uo_out  = pixel_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_monish_mandala_art.sv
// Scoreboard bench for the mandala tile: a driver pushes the expected pixel for
// every clock, a monitor pops and compares one cycle later, with per-line hsync checks.
module tb_tt_um_monish_mandala_art;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        int         h;
        int         v;
        logic [7:0] expected;
    } pixel_t;

    pixel_t expQ[$];
    int     checks = 0;
    int     passes = 0;
    bit     running = 1'b0;
    int     pixelIndex = 0;
    int     modelPhase = 0;
    int     lowCount = 0;
    int     firstLowH = -1;

    tt_um_monish_mandala_art dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #20 clk = ~clk;

    // Reference pixel straight from the geometric rules: distances, max/min, arithmetic colour.
    function automatic logic [7:0] refPixel(input int h, input int v, input logic [7:0] ui, input int phase);
        int         ax, ay, a, b, s, x, c;
        logic       hs, vs;
        logic [5:0] cc;
        hs = !(h >= 656 && h <= 751);
        vs = !(v == 490 || v == 491);
        c  = 0;
        if (h < 640 && v < 480) begin
            ax = (h > 320) ? h - 320 : 320 - h;
            ay = (v > 240) ? v - 240 : 240 - v;
            a  = (ax > ay) ? ax : ay;
            b  = (ax > ay) ? ay : ax;
            s  = a + b;
            x  = a ^ b;
            c  = ((s / 4) % 64 + (x / 4) % 64 + phase + int'(ui[7:2])) % 64;
        end
        cc = 6'(c);
        return {hs, cc[0], cc[2], cc[4], vs, cc[1], cc[3], cc[5]};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Called at a falling edge; queues the expected pixel for each upcoming rising edge.
    task automatic applyStimulus(input int nCycles);
        pixel_t p;
        for (int i = 0; i < nCycles; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                ui_in = 8'($urandom);
            end
            p.h        = pixelIndex % 800;
            p.v        = (pixelIndex / 800) % 525;
            p.expected = refPixel(p.h, p.v, ui_in, modelPhase);
            expQ.push_back(p);
`ifdef MANDALA_ANIM_EN
            if (p.h == 799 && p.v == 524 && ui_in[0]) begin
                modelPhase = (modelPhase + 1) % 64;
            end
`endif
            pixelIndex++;
            running = 1'b1;
            @(negedge clk);
        end
    endtask

    // Monitor: every registered pixel is compared against the head of the queue.
    always begin
        pixel_t p;
        @(posedge clk);
        #1;
        if (running) begin
            if (expQ.size() == 0) begin
                checkCount("queue_empty", 0, 1);
            end else begin
                p = expQ.pop_front();
                checkOutput("pixel", uo_out, p.expected);
                if (p.h == 0) begin
                    lowCount  = 0;
                    firstLowH = -1;
                end
                if (!uo_out[7]) begin
                    if (firstLowH < 0) firstLowH = p.h;
                    lowCount++;
                end
                if (p.h == 799) begin
                    checkCount("hsync_low_len", lowCount, 96);
                    checkCount("hsync_first_low", firstLowH, 656);
                    checkOutput("uio_oe", uio_oe, 8'h00);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_uo", uo_out, 8'h88);
        checkOutput("reset_uio_out", uio_out, 8'h00);
        checkOutput("reset_uio_oe", uio_oe, 8'h00);

        rst_n = 1'b1;
        applyStimulus(40 * 800 + int'($urandom_range(0, 799)));

        running = 1'b0;
        uio_in  = 8'hFF;
        rst_n   = 1'b0;
        #1;
        checkOutput("midreset_uo", uo_out, 8'h88);
        repeat (2) @(negedge clk);
        checkOutput("midreset_hold_uo", uo_out, 8'h88);
        checkOutput("midreset_uio_out", uio_out, 8'h00);

        pixelIndex = 0;
        modelPhase = 0;
        rst_n      = 1'b1;
        applyStimulus(20 * 800);

        running = 1'b0;
        @(negedge clk);
        checkCount("queue_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_monish_mandala_art.md
Name: tt_um_monish_mandala_art

Overview:
- TinyTapeout user tile that generates a VGA 640x480@60 Hz video signal with an 8-fold-symmetric "mandala" colour pattern.
- Output format is RGB222 on the TinyVGA pin mapping of uo_out.
- ui_in selects a palette offset and an animation enable.
- The bidirectional pins are unused.

Parameters:
- None. Timing constants are fixed in the package.

Ports:
- clk  input  1  pixel clock, nominal 25.175 MHz (25 MHz acceptable)
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  tile enable; ignored by logic
- ui_in  input  8  [0] animate enable; [1] reserved, ignored; [7:2] palette offset
- uo_out  output  8  [7]=hsync, [6]=B0, [5]=G0, [4]=R0, [3]=vsync, [2]=B1, [1]=G1, [0]=R1
- uio_in  input  8  unused
- uio_out  output  8  tied to 0
- uio_oe  output  8  tied to 0 (all inputs)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Counters:
  - hcount runs 0..799 and wraps to 0.
  - vcount runs 0..524 and increments when hcount wraps; vcount wraps to 0 after 524.
- Sync timing:
  - Visible area: hcount<640 and vcount<480.
  - hsync is low for hcount 656..751, high otherwise.
  - vsync is low for vcount 490..491, high otherwise.
- Fold for 8-fold symmetry:
  - ax = |hcount-320| and ay = |vcount-240|, each 10-bit unsigned.
  - a = max(ax,ay), b = min(ax,ay).
- Colour index:
  - s = a+b (11-bit), x = a^b.
  - c = (s[7:2] + x[7:2] + phase + ui_in[7:2]) mod 64, 6 bits.
  - R = c[5:4], G = c[3:2], B = c[1:0].
  - Outside the visible area, R, G and B are 0.
- Phase:
  - 6-bit register.
  - Increments by 1 when hcount=799, vcount=524 and ui_in[0]=1 (i.e. once per frame); otherwise holds.
  - Wraps mod 64.
- Latency:
  - uo_out is fully registered.
  - The value on uo_out during cycle t+1 corresponds to the counter state (hcount,vcount) during cycle t.
  - hsync/vsync travel through the same pipeline stage, so sync and colour stay aligned.
- Reset:
  - hcount=0, vcount=0, phase=0.
  - uo_out = 0x88 (hsync=1, vsync=1, RGB=0).
  - After rst_n rises, the counter advances on the first clk edge. The first registered pixel, for (0,0), appears after that edge.
  - Reset asserted mid-frame returns everything to these values immediately.
- ui_in changes take effect on the next registered pixel; there is no synchronisation requirement beyond the single register.

Optional Feature:
- MANDALA_ANIM_EN
  - Defined: the phase register and per-frame increment exist as described.
  - Undefined: phase is the constant 0, ui_in[0] is ignored, and the pattern is static.
  - All other behaviour is identical.

Decomposition:
- Package mandala_pkg holds:
  - H_VISIBLE=640, H_SYNC_START=656, H_SYNC_END=751, H_TOTAL=800
  - V_VISIBLE=480, V_SYNC_START=490, V_SYNC_END=491, V_TOTAL=525
  - CENTER_X=320, CENTER_Y=240
- One sub-module, mandala_vga_timing, produces hcount, vcount, visible, hsync_n, vsync_n and frame_end (combinational from the counters).
- The top module contains the fold/colour logic, the phase register and the output register.

Test Plan:
- Reset: hold rst_n=0 with clk running, ui_in=0x00 -> uo_out=0x88, uio_out=0x00, uio_oe=0x00.
- Centre pixel: ui_in=0x04; sample the pixel registered from counters (320,240), i.e. 240*800+320+1 clocks after reset release -> uo_out=0xC8 (c=1, B0 set).
- Off-centre and symmetry: ui_in=0x00; pixels (330,240), (310,240), (320,250), (320,230) -> each uo_out=0xA8 (c=4, G0 set).
- Sync timing: over one line, hsync (uo_out[7]) is low for exactly 96 consecutive cycles beginning with the pixel for hcount=656. Over one frame, vsync (uo_out[3]) is low for exactly 1600 cycles (lines 490-491). Frame period is 420000 cycles.
- Blanking: any pixel with hcount>=640 or vcount>=480 -> uo_out colour bits [6:4] and [2:0] are all 0.
- Animation (MANDALA_ANIM_EN defined): ui_in=0x01, run 2 full frames -> centre pixel c=2, so uo_out=0x8C (B1 set). With ui_in[0]=0, the centre pixel stays at c=0, so uo_out=0x88.
